// File: rtl/snake_engine_if.sv
// rtl/snake_engine_if.sv - game control, direction, apple and pixel-query signals of the snake engine
interface snake_engine_if;
    logic       start;
    logic       game_tick;
    logic [1:0] dir_in;
    logic       dir_valid;
    logic [5:0] apple_x;
    logic [4:0] apple_y;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [1:0] snake;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [5:0] length;
    logic       eat;
    logic       dead;

    modport master (
        output start, game_tick, dir_in, dir_valid, apple_x, apple_y, x_pos, y_pos,
        input  snake, head_x, head_y, length, eat, dead
    );

    modport slave (
        input  start, game_tick, dir_in, dir_valid, apple_x, apple_y, x_pos, y_pos,
        output snake, head_x, head_y, length, eat, dead
    );
endinterface

// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - snake segment list, movement/collision FSM and per-pixel cell query; SNAKE_WRAP_EN selects wrap-around instead of walls
module snake_engine #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30
) (
    input  logic           clk,
    input  logic           rst_n,
    snake_engine_if.slave  bus
);
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;
    localparam logic [5:0] START_X   = 6'(GRID_W / 2);
    localparam logic [4:0] START_Y   = 5'(GRID_H / 2);
    localparam logic [5:0] LAST_X    = 6'(GRID_W - 1);
    localparam logic [4:0] LAST_Y    = 5'(GRID_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_DEAD} state_t;

    state_t     state, state_nx;
    logic [5:0] seg_x [MAX_LEN];
    logic [4:0] seg_y [MAX_LEN];
    logic [5:0] length;
    logic [1:0] cur_dir, pend_dir, step_dir;
    logic       eat;
    logic [5:0] nx;
    logic [4:0] ny;
    logic       apple_hit, wall_hit, body_hit, do_step, do_init;
    logic [1:0] code;
    logic [5:0] cx;
    logic [4:0] cy;

    // Next head position; wraps at the edges, which only matters when walls are disabled.
    always_comb begin
        nx = seg_x[0];
        ny = seg_y[0];
        case (step_dir)
            DIR_UP:    ny = (seg_y[0] == 5'd0)   ? LAST_Y : seg_y[0] - 5'd1;
            DIR_DOWN:  ny = (seg_y[0] == LAST_Y) ? 5'd0   : seg_y[0] + 5'd1;
            DIR_LEFT:  nx = (seg_x[0] == 6'd0)   ? LAST_X : seg_x[0] - 6'd1;
            default:   nx = (seg_x[0] == LAST_X) ? 6'd0   : seg_x[0] + 6'd1;
        endcase
        apple_hit = (nx == bus.apple_x) && (ny == bus.apple_y);
`ifdef SNAKE_WRAP_EN
        wall_hit = 1'b0;
`else
        wall_hit = (nx == 6'd0) || (nx == LAST_X) || (ny == 5'd0) || (ny == LAST_Y);
`endif
        // The tail cell vacates on a plain move but stays occupied when eating.
        body_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (((i < int'(length) - 1) || (apple_hit && i == int'(length) - 1)) &&
                seg_x[i] == nx && seg_y[i] == ny)
                body_hit = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        do_step  = 1'b0;
        do_init  = 1'b0;
        case (state)
            S_IDLE: if (bus.start) begin state_nx = S_RUN; do_init = 1'b1; end
            S_RUN:  if (bus.game_tick) state_nx = S_STEP;
            S_STEP: begin
                if (wall_hit || body_hit) state_nx = S_DEAD;
                else begin state_nx = S_RUN; do_step = 1'b1; end
            end
            default: if (bus.start) begin state_nx = S_RUN; do_init = 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || do_init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? START_X - 6'(i) : 6'd0;
                seg_y[i] <= START_Y;
            end
            length   <= 6'(INIT_LEN);
            cur_dir  <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
            step_dir <= DIR_RIGHT;
            eat      <= 1'b0;
        end else begin
            eat <= 1'b0;
            // Reverse of a direction differs only in bit 0.
            if (bus.dir_valid && bus.dir_in != (cur_dir ^ 2'b01))
                pend_dir <= bus.dir_in;
            // Snapshot at tick acceptance so a same-cycle request waits for the next tick.
            if (state == S_RUN && bus.game_tick)
                step_dir <= pend_dir;
            if (do_step) begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nx;
                seg_y[0] <= ny;
                cur_dir  <= step_dir;
                if (apple_hit) begin
                    eat <= 1'b1;
                    if (int'(length) < MAX_LEN) length <= length + 6'd1;
                end
            end
        end
    end

    always_comb begin
        cx   = bus.x_pos[9:4];
        cy   = bus.y_pos[8:4];
        code = 2'b00;
        if (int'(bus.x_pos) < GRID_W * 16 && int'(bus.y_pos) < GRID_H * 16) begin
`ifndef SNAKE_WRAP_EN
            if (cx == 6'd0 || cx == LAST_X || cy == 5'd0 || cy == LAST_Y) code = 2'b11;
`endif
            for (int i = 1; i < MAX_LEN; i++) begin
                if (i < int'(length) && seg_x[i] == cx && seg_y[i] == cy) code = 2'b10;
            end
            if (seg_x[0] == cx && seg_y[0] == cy) code = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) bus.snake <= 2'b00;
        else        bus.snake <= code;
    end

    assign bus.head_x = seg_x[0];
    assign bus.head_y = seg_y[0];
    assign bus.length = length;
    assign bus.eat    = eat;
    assign bus.dead   = (state == S_DEAD);
endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - directed self-checking bench for snake_engine
module tb_snake_engine;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    snake_engine_if bus ();
    snake_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) bus.game_tick = 1'b1;
        @(negedge clk) bus.game_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_dir(input logic [1:0] d);
        @(negedge clk) begin bus.dir_valid = 1'b1; bus.dir_in = d; end
        @(negedge clk) bus.dir_valid = 1'b0;
    endtask

    task automatic query(input int x, input int y, input logic [1:0] exp, input string tag);
        @(negedge clk) begin bus.x_pos = 10'(x); bus.y_pos = 10'(y); end
        @(negedge clk) chk(tag, 16'(bus.snake), 16'(exp));
        bus.x_pos = 10'd700;
    endtask

    task automatic restart();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) begin rst_n = 1'b1; bus.start = 1'b1; end
        @(negedge clk) bus.start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.game_tick = 1'b0; bus.dir_in = 2'd0; bus.dir_valid = 1'b0;
        bus.apple_x = 6'd0; bus.apple_y = 5'd0; bus.x_pos = 10'd700; bus.y_pos = 10'd0;
        @(negedge clk);
        chk("rst_snake", 16'(bus.snake), 16'd0);
        chk("rst_len", 16'(bus.length), 16'd3);
        chk("rst_hx", 16'(bus.head_x), 16'd20);
        chk("rst_hy", 16'(bus.head_y), 16'd15);
        chk("rst_dead", 16'(bus.dead), 16'd0);
        chk("rst_eat", 16'(bus.eat), 16'd0);
        rst_n = 1'b1;

        // idle layout pixel queries
        query(320, 240, 2'b01, "q_head");
        query(310, 245, 2'b10, "q_body");
        query(5, 100, 2'b11, "q_wall");
        query(700, 240, 2'b00, "q_offscreen");
        query(320, 480, 2'b00, "q_offscreen_y");

        // start and three plain moves
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (3) tick();
        chk("run_hx", 16'(bus.head_x), 16'd23);
        chk("run_hy", 16'(bus.head_y), 16'd15);
        chk("run_len", 16'(bus.length), 16'd3);
        query(336, 240, 2'b10, "run_tail_21");
        query(320, 240, 2'b00, "run_vacated_20");

        // apple eating
        restart();
        bus.apple_x = 6'd21; bus.apple_y = 5'd15;
        tick();
        chk("eat_pulse", 16'(bus.eat), 16'd1);
        chk("eat_len", 16'(bus.length), 16'd4);
        chk("eat_hx", 16'(bus.head_x), 16'd21);
        bus.apple_x = 6'd0; bus.apple_y = 5'd0;
        @(negedge clk) chk("eat_one_cycle", 16'(bus.eat), 16'd0);
        query(288, 240, 2'b10, "eat_tail_18");
        tick();
        chk("noeat_pulse", 16'(bus.eat), 16'd0);
        chk("noeat_len", 16'(bus.length), 16'd4);
        chk("noeat_hx", 16'(bus.head_x), 16'd22);

        // direction: reversal ignored, same-cycle request deferred
        restart();
        set_dir(2'd2);
        tick();
        chk("rev_hx", 16'(bus.head_x), 16'd21);
        chk("rev_hy", 16'(bus.head_y), 16'd15);
        @(negedge clk) begin bus.game_tick = 1'b1; bus.dir_valid = 1'b1; bus.dir_in = 2'd0; end
        @(negedge clk) begin bus.game_tick = 1'b0; bus.dir_valid = 1'b0; end
        @(negedge clk);
        chk("same_tick_hx", 16'(bus.head_x), 16'd22);
        chk("same_tick_hy", 16'(bus.head_y), 16'd15);
        tick();
        chk("next_tick_hx", 16'(bus.head_x), 16'd22);
        chk("next_tick_hy", 16'(bus.head_y), 16'd14);

`ifndef SNAKE_WRAP_EN
        // wall collision
        restart();
        repeat (18) tick();
        chk("wall_pre_hx", 16'(bus.head_x), 16'd38);
        chk("wall_pre_dead", 16'(bus.dead), 16'd0);
        tick();
        chk("wall_dead", 16'(bus.dead), 16'd1);
        chk("wall_hx", 16'(bus.head_x), 16'd38);
        tick();
        chk("wall_frozen_hx", 16'(bus.head_x), 16'd38);
        chk("wall_still_dead", 16'(bus.dead), 16'd1);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        chk("restart_hx", 16'(bus.head_x), 16'd20);
        chk("restart_len", 16'(bus.length), 16'd3);
        chk("restart_dead", 16'(bus.dead), 16'd0);
`else
        // wrap-around instead of walls
        restart();
        repeat (18) tick();
        chk("wrap_pre_hx", 16'(bus.head_x), 16'd38);
        tick();
        chk("wrap_39", 16'(bus.head_x), 16'd39);
        chk("wrap_39_dead", 16'(bus.dead), 16'd0);
        tick();
        chk("wrap_0", 16'(bus.head_x), 16'd0);
        chk("wrap_0_dead", 16'(bus.dead), 16'd0);
        query(5, 100, 2'b00, "wrap_no_wall");
`endif

        // self-collision at length 5
        restart();
        bus.apple_x = 6'd21; bus.apple_y = 5'd15;
        tick();
        bus.apple_x = 6'd22;
        tick();
        bus.apple_x = 6'd0; bus.apple_y = 5'd0;
        chk("self_len", 16'(bus.length), 16'd5);
        set_dir(2'd0);
        tick();
        set_dir(2'd2);
        tick();
        chk("self_pre_hx", 16'(bus.head_x), 16'd21);
        chk("self_pre_hy", 16'(bus.head_y), 16'd14);
        chk("self_pre_dead", 16'(bus.dead), 16'd0);
        set_dir(2'd1);
        tick();
        chk("self_dead", 16'(bus.dead), 16'd1);
        chk("self_hy", 16'(bus.head_y), 16'd14);
        chk("self_len_kept", 16'(bus.length), 16'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
